seg7_scan_ctrl: RTL

SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

---
 rtl/seg7_scan_ctrl.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/seg7_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg7_scan_ctrl
// Multiplexed 4-digit seven-segment scan controller with tear-free updates.
// Each digit is lit for SCAN_DIV cycles. Between digits all digits are dark for
// GAP_CYC cycles so the segment drivers can settle (anti-ghosting). A new
// display value is held in a shadow register. It is copied to the displayed
// (committed) register only at the frame boundary, so one frame never shows a
// mix of old and new digits.
//
// Parameters
//   SCAN_DIV  cycles each digit is lit
//   GAP_CYC   cycles all digits are dark between digits (>= 1)
// Ports
//   CLK       system clock
//   RST       asynchronous active-high reset
//   wr_valid  new display value offered
//   wr_ready  controller can accept a value (no write pending)
//   wr_data   four BCD digits, [3:0] = digit 0 (rightmost)
//   wr_dp     decimal-point enables, bit i = digit i
//   blank_lz  leading-zero blanking enable, sampled live
//   seg       {A,B,C,D,E,F,G,DP}, active-high, registered
//   dig_en    digit enables, active-high, one-hot or zero, registered
// -----------------------------------------------------------------------------
module seg7_scan_ctrl #(
  parameter int SCAN_DIV = 4000,
  parameter int GAP_CYC  = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [15:0] wr_data,
  input  logic [3:0]  wr_dp,
  input  logic        blank_lz,
  output logic [7:0]  seg,
  output logic [3:0]  dig_en
);

  localparam int MAX_CYC = (SCAN_DIV > GAP_CYC) ? SCAN_DIV : GAP_CYC;
  localparam int CW      = $clog2(MAX_CYC + 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYC - 1);
  localparam logic [CW-1:0] SHOW_LAST = CW'(SCAN_DIV - 1);

  typedef enum logic {
    ST_GAP  = 1'b0,
    ST_SHOW = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    seg_q, seg_d;
  logic [3:0]    dig_en_q, dig_en_d;
  logic [15:0]   com_data_q, com_data_d;
  logic [3:0]    com_dp_q, com_dp_d;
  logic [15:0]   sh_data_q, sh_data_d;
  logic [3:0]    sh_dp_q, sh_dp_d;
  logic          pend_q, pend_d;

  logic          frame_end;
  logic          wr_accept;
  logic [3:0]    digit_val;
  logic [7:0]    glyph;

  // Segment pattern for one digit value. DP bit is always 0 here. A-F show a dash.
  function automatic logic [7:0] seg7_decode(input logic [3:0] val);
    logic [7:0] pat;
    case (val)
      4'd0:    pat = 8'hFC;
      4'd1:    pat = 8'h60;
      4'd2:    pat = 8'hDA;
      4'd3:    pat = 8'hF2;
      4'd4:    pat = 8'h66;
      4'd5:    pat = 8'hB6;
      4'd6:    pat = 8'hBE;
      4'd7:    pat = 8'hE0;
      4'd8:    pat = 8'hFE;
      4'd9:    pat = 8'hF6;
      default: pat = 8'h02;
    endcase
    return pat;
  endfunction

  // Select the 4-bit digit at position idx.
  function automatic logic [3:0] digit_sel(input logic [15:0] data, input logic [1:0] idx);
    logic [3:0] d;
    case (idx)
      2'd0:    d = data[3:0];
      2'd1:    d = data[7:4];
      2'd2:    d = data[11:8];
      2'd3:    d = data[15:12];
      default: d = 4'd0;
    endcase
    return d;
  endfunction

  // A digit is a leading zero when it and every higher digit are zero.
  // Digit 0 always stays visible.
  function automatic logic lz_blank(input logic [15:0] data, input logic [1:0] idx);
    logic b;
    case (idx)
      2'd0:    b = 1'b0;
      2'd1:    b = (data[15:4]  == 12'd0);
      2'd2:    b = (data[15:8]  == 8'd0);
      2'd3:    b = (data[15:12] == 4'd0);
      default: b = 1'b0;
    endcase
    return b;
  endfunction

  assign wr_ready  = ~pend_q;
  assign wr_accept = wr_valid & ~pend_q;
  assign seg       = seg_q;
  assign dig_en    = dig_en_q;

  // Scan sequencer: one phase counter serves both GAP and SHOW.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q + {{(CW-1){1'b0}}, 1'b1};
    frame_end = 1'b0;
    case (state_q)
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = ST_SHOW;
          cnt_d   = {CW{1'b0}};
        end else begin
          state_d = ST_GAP;
        end
      end
      ST_SHOW: begin
        if (cnt_q == SHOW_LAST) begin
          state_d   = ST_GAP;
          idx_d     = idx_q + 2'd1;
          cnt_d     = {CW{1'b0}};
          frame_end = (idx_q == 2'd3);
        end else begin
          state_d = ST_SHOW;
        end
      end
      default: begin
        state_d = ST_GAP;
        idx_d   = 2'd0;
        cnt_d   = {CW{1'b0}};
      end
    endcase
  end

  // Write path. Commit and accept never happen together: commit needs
  // pending=1, accept needs pending=0.
  always_comb begin
    com_data_d = com_data_q;
    com_dp_d   = com_dp_q;
    sh_data_d  = sh_data_q;
    sh_dp_d    = sh_dp_q;
    pend_d     = pend_q;
    if (frame_end && pend_q) begin
      com_data_d = sh_data_q;
      com_dp_d   = sh_dp_q;
      pend_d     = 1'b0;
    end else if (wr_accept) begin
      sh_data_d = wr_data;
      sh_dp_d   = wr_dp;
      pend_d    = 1'b1;
    end else begin
      pend_d = pend_q;
    end
  end

  // Output values for the next state, so seg/dig_en change on the same edge as the state.
  // SHOW is only entered from GAP, and no commit happens there, so the
  // current committed value is the one being displayed.
  always_comb begin
    seg_d     = 8'h00;
    dig_en_d  = 4'b0000;
    digit_val = digit_sel(com_data_q, idx_d);
    glyph     = seg7_decode(digit_val);
    if (state_d == ST_SHOW) begin
      if (blank_lz && lz_blank(com_data_q, idx_d)) begin
        glyph = 8'h00;
      end else begin
        glyph = seg7_decode(digit_val);
      end
      dig_en_d = 4'b0001 << idx_d;
      seg_d    = {glyph[7:1], com_dp_q[idx_d]};
    end else begin
      seg_d    = 8'h00;
      dig_en_d = 4'b0000;
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_GAP;
      idx_q      <= 2'd0;
      cnt_q      <= {CW{1'b0}};
      seg_q      <= 8'h00;
      dig_en_q   <= 4'b0000;
      com_data_q <= 16'h0000;
      com_dp_q   <= 4'b0000;
      sh_data_q  <= 16'h0000;
      sh_dp_q    <= 4'b0000;
      pend_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      seg_q      <= seg_d;
      dig_en_q   <= dig_en_d;
      com_data_q <= com_data_d;
      com_dp_q   <= com_dp_d;
      sh_data_q  <= sh_data_d;
      sh_dp_q    <= sh_dp_d;
      pend_q     <= pend_d;
    end
  end

endmodule
